// File: rtl/mcpu_vram_sched.sv
// VRAM access scheduler: shares the GPU's single host VRAM port between the CPU
// and a constant-byte fill engine using a 3-state sequencer and round-robin arbitration.
module mcpu_vram_sched #(
    parameter bit FILL_BLANK_ONLY = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        display_on,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [12:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_ack,
    output logic [7:0]  cpu_rdata,
    input  logic        fill_start,
    input  logic [12:0] fill_addr,
    input  logic [13:0] fill_len,
    input  logic [7:0]  fill_value,
    output logic        fill_busy,
    output logic        fill_done,
    output logic [12:0] vram_addr,
    output logic        vram_re,
    output logic        vram_we,
    output logic [7:0]  vram_wdata,
    input  logic [7:0]  vram_rdata
);

    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_DONE} state_t;

    state_t      state;
    logic        last_fill;
    logic        grant_fill;
    logic [12:0] f_addr;
    logic [13:0] f_cnt;
    logic [7:0]  f_value;
    logic        fill_cand;

    assign fill_cand = fill_busy && (!FILL_BLANK_ONLY || !display_on);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            last_fill  <= 1'b1;
            grant_fill <= 1'b0;
            f_addr     <= '0;
            f_cnt      <= '0;
            f_value    <= '0;
            vram_addr  <= '0;
            vram_re    <= 1'b0;
            vram_we    <= 1'b0;
            vram_wdata <= '0;
            cpu_ack    <= 1'b0;
            cpu_rdata  <= '0;
            fill_busy  <= 1'b0;
            fill_done  <= 1'b0;
        end else begin
            cpu_ack   <= 1'b0;
            fill_done <= 1'b0;

            // Start can never coincide with a fill count update: one needs busy=0, the other busy=1.
            if (fill_start && !fill_busy && fill_len != 14'd0) begin
                f_addr    <= fill_addr;
                f_cnt     <= fill_len;
                f_value   <= fill_value;
                fill_busy <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (cpu_req && (!fill_cand || last_fill)) begin
                        vram_addr  <= cpu_addr;
                        vram_we    <= cpu_we;
                        vram_re    <= !cpu_we;
                        vram_wdata <= cpu_wdata;
                        grant_fill <= 1'b0;
                        last_fill  <= 1'b0;
                        state      <= ST_ACCESS;
                    end else if (fill_cand) begin
                        vram_addr  <= f_addr;
                        vram_we    <= 1'b1;
                        vram_re    <= 1'b0;
                        vram_wdata <= f_value;
                        grant_fill <= 1'b1;
                        last_fill  <= 1'b1;
                        state      <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    vram_we <= 1'b0;
                    vram_re <= 1'b0;
                    state   <= ST_DONE;
                    if (grant_fill) begin
                        f_addr <= f_addr + 13'd1;
                        f_cnt  <= f_cnt - 14'd1;
                        if (f_cnt == 14'd1) begin
                            fill_done <= 1'b1;
                            fill_busy <= 1'b0;
                        end
                    end else begin
                        cpu_ack <= 1'b1;
                        if (vram_re)
                            cpu_rdata <= vram_rdata;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
